// File: rtl/top_level.sv
// top_level: board-level 8-bit ALU; buttons latch A, B and opcode from switches, LEDs show the result.
// Optional BTN_EDGE_SYNC_EN: synchronise buttons and load once per press on the rising edge.
module top_level #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               btnU,
  input  logic [NB_DATA-1:0] sw,
  input  logic               btnL,
  input  logic               btnR,
  input  logic               btnC,
  output logic [NB_DATA-1:0] led
);
  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;
  logic [NB_DATA-1:0] r_a, r_b;
  logic [NB_OP-1:0]   r_op;
  logic [2:0]         w_load;
`ifdef BTN_EDGE_SYNC_EN
  logic [2:0] r_sync1, r_sync2, r_prev;
  always_ff @(posedge clk or negedge btnU)
    if (!btnU) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {btnC, btnR, btnL};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  assign w_load = r_sync2 & ~r_prev;
`else
  assign w_load = {btnC, btnR, btnL};
`endif
  always_ff @(posedge clk or negedge btnU)
    if (!btnU) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else begin
      if (w_load[0]) r_a  <= sw;
      if (w_load[1]) r_b  <= sw;
      if (w_load[2]) r_op <= sw[NB_OP-1:0];
    end
  // Shift amounts of NB_DATA or more naturally saturate to sign fill / zero.
  always_comb begin
    led = '0;
    case (r_op)
      OP_ADD:  led = r_a + r_b;
      OP_SUB:  led = r_a - r_b;
      OP_AND:  led = r_a & r_b;
      OP_OR:   led = r_a | r_b;
      OP_XOR:  led = r_a ^ r_b;
      OP_NOR:  led = ~(r_a | r_b);
      OP_SRA:  led = $unsigned($signed(r_a) >>> r_b);
      OP_SRL:  led = r_a >> r_b;
      default: led = '0;
    endcase
  end
endmodule

// File: tb/tb_top_level.sv
// tb_top_level: randomized and directed checks of top_level against an arithmetic ALU model.
module tb_top_level;
  logic       clk = 0;
  logic       btnU = 0;
  logic [7:0] sw = '0;
  logic       btnL = 0, btnR = 0, btnC = 0;
  logic [7:0] led;
  int n_checks = 0;
  int n_fail = 0;
  int ma = 0, mb = 0, mop = 0;

  top_level dut (.clk(clk), .btnU(btnU), .sw(sw), .btnL(btnL), .btnR(btnR), .btnC(btnC), .led(led));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
    int sa;
    sa = (a >= 128) ? a - 256 : a;
    case (op)
      32: return 8'((a + b) % 256);
      34: return 8'((a - b + 256) % 256);
      36: return 8'(a & b);
      37: return 8'(a | b);
      38: return 8'(a ^ b);
      39: return 8'(255 - (a | b));
      3:  return (b >= 8) ? ((a >= 128) ? 8'hFF : 8'h00) : 8'((sa >>> b) & 255);
      2:  return (b >= 8) ? 8'h00 : 8'(a >> b);
      default: return 8'h00;
    endcase
  endfunction

  task automatic press(input logic l, input logic r, input logic c, input logic [7:0] v);
    sw = v; btnL = l; btnR = r; btnC = c;
`ifdef BTN_EDGE_SYNC_EN
    repeat (3) @(posedge clk);
`else
    @(posedge clk);
`endif
    #1 btnL = 0; btnR = 0; btnC = 0;
`ifdef BTN_EDGE_SYNC_EN
    repeat (3) @(posedge clk);
`endif
    if (l) ma = int'(v);
    if (r) mb = int'(v);
    if (c) mop = int'(v[5:0]);
    @(negedge clk);
  endtask

  task automatic op_check(input string tag, input logic [7:0] op);
    press(0, 0, 1, op);
    chk(tag, led, ref_alu(ma, mb, mop));
  endtask

  initial begin
    logic [7:0] vals [10];
    int ops [8] = '{32, 34, 36, 37, 38, 39, 3, 2};
    sw = 8'h5A; btnL = 1; btnR = 1; btnC = 1;
    repeat (2) @(negedge clk);
    chk("reset_led", led, 8'h00);
    btnL = 0; btnR = 0; btnC = 0;
    @(negedge clk);
    btnU = 1;
    @(negedge clk);
    chk("post_reset_led", led, 8'h00);
    op_check("reset_regs_add", 8'h20);
    chk("reset_regs_zero", led, 8'h00);

    press(1, 0, 0, 8'hFF);
    press(0, 1, 0, 8'hF0);
    op_check("and", 8'h24);
    chk("and_const", led, 8'hF0);
    op_check("or", 8'h25);
    chk("or_const", led, 8'hFF);
    op_check("xor", 8'h26);
    chk("xor_const", led, 8'h0F);
    op_check("nor", 8'h27);
    chk("nor_const", led, 8'h00);

    press(1, 0, 0, 8'hF0);
    press(0, 1, 0, 8'h20);
    op_check("add_wrap", 8'h20);
    chk("add_wrap_const", led, 8'h10);
    press(1, 0, 0, 8'h05);
    press(0, 1, 0, 8'h07);
    op_check("sub_borrow", 8'h22);
    chk("sub_borrow_const", led, 8'hFE);

    press(1, 0, 0, 8'h80);
    press(0, 1, 0, 8'h03);
    op_check("sra3", 8'h03);
    chk("sra3_const", led, 8'hF0);
    op_check("srl3", 8'h02);
    chk("srl3_const", led, 8'h10);
    press(0, 1, 0, 8'h09);
    op_check("srl9", 8'h02);
    chk("srl9_const", led, 8'h00);
    op_check("sra9", 8'h03);
    chk("sra9_const", led, 8'hFF);

    press(1, 1, 0, 8'h3C);
    op_check("dual_load_add", 8'h20);
    chk("dual_load_const", led, 8'h78);
    op_check("invalid_op", 8'h3F);
    chk("invalid_const", led, 8'h00);

    sw = 'x;
    repeat (3) @(negedge clk);
    chk("sw_x_idle", led, ref_alu(ma, mb, mop));

    press(1, 0, 0, 8'hFF);
    press(0, 1, 0, 8'hF0);
    op_check("pre_async_and", 8'h24);
    #2 btnU = 0;
    #1 chk("async_reset", led, 8'h00);
    ma = 0; mb = 0; mop = 0;
    @(negedge clk);
    btnU = 1;
    @(negedge clk);
    op_check("after_async_and", 8'h24);

    press(1, 0, 0, 8'h0F);
    for (int i = 0; i < 10; i++) vals[i] = 8'(i * 17 + 3);
    btnL = 1;
    for (int i = 0; i < 10; i++) begin
      sw = vals[i];
      @(posedge clk);
      #1;
    end
    btnL = 0;
`ifdef BTN_EDGE_SYNC_EN
    ma = int'(vals[2]);
    repeat (3) @(posedge clk);
`else
    ma = int'(vals[9]);
`endif
    press(0, 1, 0, 8'h00);
    op_check("hold_load_or", 8'h25);

    for (int k = 0; k < 40; k++) begin
      press(1, 0, 0, 8'($urandom));
      press(0, 1, 0, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom));
      if ($urandom_range(0, 4) == 0) op_check("rand_any", 8'($urandom));
      else op_check("rand_op", 8'(ops[$urandom_range(0, 7)]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
